// File: rtl/note_recorder_pkg.sv
// Shared song-entry definitions: note/octave codes, entry field widths, FSM encoding
// and the key/pitch encoders used by the recorder (auto_player reads the same layout).
package note_recorder_pkg;

    localparam int NOTE_W = 3;
    localparam int OCT_W  = 2;
    localparam int CODE_W = OCT_W + NOTE_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_DO   = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_RE   = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_MI   = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_FA   = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_SOL  = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_LA   = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_SI   = 3'd7;

    localparam logic [OCT_W-1:0] OCT_MID  = 2'b00;
    localparam logic [OCT_W-1:0] OCT_LOW  = 2'b01;
    localparam logic [OCT_W-1:0] OCT_HIGH = 2'b10;

    // Bit 1 of the state doubles as the recording flag.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b10,
        ST_TRACK = 2'b11
    } state_t;

    // key[6] is do, key[0] is si; the highest pressed index wins.
    function automatic logic [NOTE_W-1:0] encode_note(input logic [6:0] keys);
        logic [NOTE_W-1:0] note;
        note = NOTE_REST;
        for (int i = 0; i < 7; i++) begin
            if (keys[i]) note = NOTE_W'(7 - i);
        end
        return note;
    endfunction

    function automatic logic [OCT_W-1:0] encode_octave(input logic [1:0] sw);
        case (sw)
            2'b01:   return OCT_LOW;
            2'b10:   return OCT_HIGH;
            default: return OCT_MID;
        endcase
    endfunction

endpackage

// File: rtl/note_recorder_debounce.sv
// Per-bit debouncer: raw inputs are synchronised, and each bit's accepted value follows
// the raw value only once it has differed continuously for CYCLES clocks.
module key_debounce #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] stable
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt [WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                // Any return to the accepted value restarts that bit's window.
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Record-mode writer for song RAM: debounces keys/pitch, times each held note in ticks and
// emits one {octave, note, dur} entry per note through the wr_* port.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int TICK_MS     = 10,
    parameter int ADDR_W      = 6,
    parameter int DUR_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic                     stop,
    input  logic [6:0]               key,
    input  logic [1:0]               pitch,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [CODE_W+DUR_W-1:0]  wr_data,
    output logic [ADDR_W:0]          length,
    output logic                     recording,
    output logic                     full
);
    localparam int DEB_CYCLES  = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int TICK_CYCLES = (CLK_HZ / 1000) * TICK_MS;
    localparam int TICK_W      = $clog2(TICK_CYCLES + 1);
    localparam logic [DUR_W-1:0] DUR_MAX = '1;

    logic [6:0]        key_db;
    logic [1:0]        pitch_db;
    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] code_q;
    logic              code_change;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    state_t            state;
    logic [CODE_W-1:0] cur_code;
    logic [DUR_W-1:0]  dur;
    logic              last_write;

    key_debounce #(.WIDTH(7), .CYCLES(DEB_CYCLES)) u_key_db (
        .clk    (clk),
        .rst    (rst),
        .raw    (key),
        .stable (key_db)
    );

    key_debounce #(.WIDTH(2), .CYCLES(DEB_CYCLES)) u_pitch_db (
        .clk    (clk),
        .rst    (rst),
        .raw    (pitch),
        .stable (pitch_db)
    );

    assign code        = {encode_octave(pitch_db), encode_note(key_db)};
    assign code_change = (code != code_q);
    assign tick        = !code_change && (tick_cnt == TICK_W'(TICK_CYCLES - 1));
    assign last_write  = wr_en && (&wr_addr);
    assign recording   = state[1];

    // Prescaler restarts on every code change so a note's first tick is a full period away.
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q   <= '0;
            tick_cnt <= '0;
        end else begin
            code_q <= code;
            if (code_change || tick) tick_cnt <= '0;
            else                     tick_cnt <= tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur_code <= '0;
            dur      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            length   <= '0;
            full     <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start && en) begin
                state   <= ST_ARMED;
                length  <= '0;
                wr_addr <= '0;
                full    <= 1'b0;
                dur     <= '0;
            end else begin
                if (wr_en) begin
                    wr_addr <= wr_addr + 1'b1;
                    length  <= length + 1'b1;
                    if (&wr_addr) begin
                        full  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                // The cycle the last slot is committed, nothing else may be recorded.
                if (!last_write) begin
                    case (state)
                        ST_IDLE: ;
                        ST_ARMED: begin
                            if (!en) begin
                                state <= ST_IDLE;
                            end else if (code[NOTE_W-1:0] != NOTE_REST) begin
                                cur_code <= code;
                                dur      <= '0;
                                state    <= ST_TRACK;
                            end
                        end
                        ST_TRACK: begin
                            if (stop || !en) begin
                                if (cur_code[NOTE_W-1:0] != NOTE_REST && dur != '0) begin
                                    wr_en   <= 1'b1;
                                    wr_data <= {cur_code, dur};
                                end
                                state <= ST_IDLE;
                            end else if (code != cur_code) begin
                                // A zero-length code is a glitch and is silently replaced.
                                if (dur != '0) begin
                                    wr_en   <= 1'b1;
                                    wr_data <= {cur_code, dur};
                                end
                                cur_code <= code;
                                dur      <= '0;
                            end else if (tick) begin
                                if (dur == DUR_MAX - 1'b1) begin
                                    wr_en   <= 1'b1;
                                    wr_data <= {cur_code, DUR_MAX};
                                    dur     <= '0;
                                end else begin
                                    dur <= dur + 1'b1;
                                end
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule
